// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one W-bit up-counter to N_REQ requesters in turn,
// counting 0..LEN[winner] for the granted client and pulsing DONE on completion.
module counter_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [N_REQ*W-1:0] LEN,
    output logic [N_REQ-1:0]   GNT,
    output logic [N_REQ-1:0]   DONE,
    output logic               BUSY,
    output logic [W-1:0]       COUNT
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     last;
    logic [IW-1:0]     last_nxt;
    logic [W-1:0]      limit;
    logic [W-1:0]      limit_nxt;
    logic [W-1:0]      count_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [N_REQ-1:0]  done_nxt;
    logic              busy_nxt;

    logic [IW-1:0]     win;
    logic              win_vld;
    logic [W-1:0]      len_arr [N_REQ];

    // Unpack the per-requester length fields.
    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_len
        assign len_arr[g] = LEN[g*W +: W];
    end

    // Round-robin search starting just after the last winner, wrapping modulo N_REQ.
    always_comb begin
        int unsigned   cand;
        logic [IW-1:0] cand_i;
        win     = last;
        win_vld = 1'b0;
        cand    = 0;
        cand_i  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = 32'(last) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_i = IW'(cand);
            if (!win_vld && REQ[cand_i]) begin
                win     = cand_i;
                win_vld = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; last doubles as the granted index during RUN.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        limit_nxt = limit;
        count_nxt = COUNT;
        gnt_nxt   = GNT;
        done_nxt  = '0;

        case (state)
            IDLE: begin
                gnt_nxt   = '0;
                count_nxt = '0;
                if (win_vld) begin
                    state_nxt = RUN;
                    limit_nxt = len_arr[win];
                    gnt_nxt   = N_REQ'(1) << win;
                    last_nxt  = win;
                end
            end
            RUN: begin
                // Abort wins over completion when both happen in the same cycle.
                if (!REQ[last]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    count_nxt = '0;
                end else if (COUNT == limit) begin
                    state_nxt = FIN;
                    gnt_nxt   = '0;
                    done_nxt  = N_REQ'(1) << last;
                end else begin
                    count_nxt = COUNT + W'(1);
                end
            end
            FIN: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                count_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                count_nxt = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            last  <= IW'(N_REQ - 1);
            limit <= '0;
            COUNT <= '0;
            GNT   <= '0;
            DONE  <= '0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            limit <= limit_nxt;
            COUNT <= count_nxt;
            GNT   <= gnt_nxt;
            DONE  <= done_nxt;
            BUSY  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: stimulus queues the expected GNT/DONE events,
// a negedge monitor pops and compares whenever the DUT shows a grant or a completion.
module tb_counter_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned W     = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] len;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic               busy;
    logic [W-1:0]       count;

    typedef struct packed {
        logic [N_REQ-1:0] gnt;
        logic [N_REQ-1:0] done;
        logic [W-1:0]     count;
        logic             busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    counter_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .REQ   (req),
        .LEN   (len),
        .GNT   (gnt),
        .DONE  (done),
        .BUSY  (busy),
        .COUNT (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic push_ev(input logic [N_REQ-1:0] g, input logic [N_REQ-1:0] d,
                           input logic [W-1:0] c);
        exp_t e;
        e = {g, d, c, 1'b1};
        exp_q.push_back(e);
    endtask

    // Full grant: COUNT 0..l under GNT, then one DONE cycle holding COUNT=l.
    task automatic push_grant(input int idx, input int l);
        logic [N_REQ-1:0] oh;
        oh = N_REQ'(1) << idx;
        for (int k = 0; k <= l; k++) push_ev(oh, '0, W'(k));
        push_ev('0, oh, W'(l));
    endtask

    task automatic wait_done(input int idx, input int budget, input string name);
        logic found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            if (done[idx] === 1'b1) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s: no DONE[%0d] within %0d cycles", name, idx, budget);
        end
    endtask

    task automatic wait_count(input int idx, input int val, input int budget, input string name);
        logic found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            if (gnt[idx] === 1'b1 && count === W'(val)) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s: no GNT[%0d] with COUNT=%0d within %0d cycles", name, idx, val, budget);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"},   32'(gnt),   32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
    endtask

    // Monitor: every cycle with a grant or completion must match the next queued event.
    always @(negedge clk) begin
        if (gnt != '0 || done != '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got gnt=%b done=%b count=%0d busy=%b, none queued",
                         gnt, done, count, busy);
            end else begin
                mon_e = exp_q.pop_front();
                if ({gnt, done, count, busy} !== mon_e) begin
                    bad++;
                    $display("FAIL event: got gnt=%b done=%b count=%0d busy=%b, expected gnt=%b done=%b count=%0d busy=%b",
                             gnt, done, count, busy, mon_e.gnt, mon_e.done, mon_e.count, mon_e.busy);
                end
            end
        end
    end

    initial begin
        int  gap;
        logic seen;

        // Reset state
        rst_n = 1'b0;
        req   = '0;
        len   = '0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;

        // Reset mid-run at COUNT=4
        len[1*W +: W] = 8'd10;
        for (int k = 0; k <= 4; k++) push_ev(4'b0010, '0, W'(k));
        req = 4'b0010;
        wait_count(1, 4, 30, "wait_mid_count4");
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        chk_quiet("midrun_reset");

        // After release, index 0 wins first, then index 1
        rst_n = 1'b1;
        len[0*W +: W] = 8'd2;
        len[1*W +: W] = 8'd1;
        push_grant(0, 2);
        push_grant(1, 1);
        req = 4'b0011;
        wait_done(0, 20, "post_reset_done0");
        req[0] = 1'b0;
        wait_done(1, 20, "post_reset_done1");
        req[1] = 1'b0;

        // Single request held: two back-to-back grants, two dead cycles apart
        repeat (2) @(negedge clk);
        len[0*W +: W] = 8'd3;
        push_grant(0, 3);
        push_grant(0, 3);
        req = 4'b0001;
        wait_done(0, 20, "single_done_a");
        gap  = 0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            gap++;
            if (gnt[0] === 1'b1) seen = 1'b1;
        end
        chk("regrant_gap", 32'(gap), 32'd2);
        wait_done(0, 20, "single_done_b");
        req = '0;

        // Fairness after a fresh reset: order 0,1,2,3,0,1
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        len = {4{8'd1}};
        push_grant(0, 1);
        push_grant(1, 1);
        push_grant(2, 1);
        push_grant(3, 1);
        push_grant(0, 1);
        push_grant(1, 1);
        req = 4'b1111;
        wait_done(0, 20, "fair_done0");
        wait_done(1, 20, "fair_done1");
        wait_done(2, 20, "fair_done2");
        wait_done(3, 20, "fair_done3");
        wait_done(0, 20, "fair_done0b");
        wait_done(1, 20, "fair_done1b");
        req = '0;

        // Zero length
        repeat (2) @(negedge clk);
        len[2*W +: W] = 8'd0;
        push_grant(2, 0);
        req = 4'b0100;
        wait_done(2, 20, "zero_done");
        req = '0;

        // Abort mid-run at COUNT=2
        repeat (2) @(negedge clk);
        len[2*W +: W] = 8'd5;
        for (int k = 0; k <= 2; k++) push_ev(4'b0100, '0, W'(k));
        req = 4'b0100;
        wait_count(2, 2, 20, "wait_abort_c2");
        req = '0;
        @(negedge clk);
        chk_quiet("abort_mid");
        repeat (3) @(negedge clk);

        // Abort exactly at COUNT==LIMIT: no DONE
        len[2*W +: W] = 8'd3;
        for (int k = 0; k <= 3; k++) push_ev(4'b0100, '0, W'(k));
        req = 4'b0100;
        wait_count(2, 3, 20, "wait_abort_lim");
        req = '0;
        @(negedge clk);
        chk_quiet("abort_limit");
        repeat (3) @(negedge clk);

        // Full range: 0..255 without wrap
        len[0*W +: W] = 8'd255;
        push_grant(0, 255);
        req = 4'b0001;
        wait_done(0, 300, "full_done");
        req = '0;

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
